multicycle_control_fsm: RTL
===========================

# multicycle_control_fsm

Sequencing controller that turns the single-cycle MIPS datapath into a multicycle one. Shared memory serves both fetch and data access. It replaces the combinational `Control` decode with a Moore state machine that steps each instruction through fetch, decode, execute, memory and writeback. It drives the enables and mux selects for PC, IR, memory, register file and ALU. It stalls on a memory-ready handshake so variable-latency memory can be attached.

## Interface
Parameters:
- `CNT_WIDTH`, default 32: width of the performance counters.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `OP`  in  6  opcode from the instruction register (IR[31:26]); stable from DECODE onward.
- `mem_ready`  in  1  memory completes the current read or write this cycle.
- `PCWrite`  out  1  unconditional PC load.
- `PCWriteCondEQ`  out  1  PC load if ALU Zero (beq).
- `PCWriteCondNE`  out  1  PC load if ALU !Zero (bne).
- `PCSource`  out  2  00 ALU result, 01 ALUOut register, 10 jump target.
- `IorD`  out  1  memory address select: 0 PC, 1 ALUOut.
- `MemRead`  out  1  memory read strobe.
- `MemWrite`  out  1  memory write strobe.
- `IRWrite`  out  1  IR load.
- `RegDst`  out  1  write register select: 0 rt, 1 rd.
- `MemtoReg`  out  1  writeback select: 0 ALUOut, 1 MDR.
- `RegWrite`  out  1  register file write.
- `ALUSrcA`  out  1  ALU A select: 0 PC, 1 register A.
- `ALUSrcB`  out  2  ALU B select: 00 register B, 01 constant 4, 10 sign-extended immediate, 11 immediate<<2.
- `ALUOp`  out  3  ALU op code: 000 add, 001 sub, 010 funct, 011 or, 100 and, 101 lui.
- `illegal_op`  out  1  high while in TRAP.
- `state_out`  out  4  current state encoding.
- `cycle_count`  out  CNT_WIDTH  performance counter.
- `instr_count`  out  CNT_WIDTH  performance counter.

## Operation
Recognised opcodes: R 0x00, j 0x02, beq 0x04, bne 0x05, addi 0x08, andi 0x0C, ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B.

Outputs are decoded from the state only (Moore). Exceptions: IRWrite and PCWrite in FETCH are ANDed with `mem_ready`. Any signal not listed for a state is 0.

- FETCH (0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=add, PCSource=00, IRWrite=PCWrite=mem_ready.
  - Stays in FETCH while `mem_ready`=0; goes to DECODE when `mem_ready`=1.
- DECODE (1): ALUSrcA=0, ALUSrcB=11, ALUOp=add (branch target into ALUOut). Next state by `OP`:
  - lw/sw → MEM_ADDR
  - R → R_EXEC
  - beq/bne → BRANCH
  - j → JUMP
  - addi/andi/ori/lui → I_EXEC
  - anything else → TRAP
- MEM_ADDR (2): ALUSrcA=1, ALUSrcB=10, add. Goes to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ (3): MemRead=1, IorD=1. Waits for `mem_ready`, then MEM_WB.
- MEM_WB (4): RegWrite=1, MemtoReg=1, RegDst=0. Goes to FETCH.
- MEM_WRITE (5): MemWrite=1, IorD=1. Held until `mem_ready`, then FETCH.
- R_EXEC (6): ALUSrcA=1, ALUSrcB=00, ALUOp=funct. Goes to R_WB.
- R_WB (7): RegWrite=1, RegDst=1. Goes to FETCH.
- BRANCH (8): ALUSrcA=1, ALUSrcB=00, sub, PCSource=01. Asserts PCWriteCondEQ for beq, PCWriteCondNE for bne. Goes to FETCH.
- JUMP (9): PCWrite=1, PCSource=10. Goes to FETCH.
- I_EXEC (10): ALUSrcA=1, ALUSrcB=10. ALUOp is add for addi, and for andi, or for ori, lui for lui. Goes to I_WB.
- I_WB (11): RegWrite=1, RegDst=0, MemtoReg=0. Goes to FETCH.
- TRAP (12): illegal_op=1, all strobes 0. Terminal; only reset exits.

## Timing
- Reset is asynchronous.
  - Asserting `reset` immediately forces state FETCH.
  - While `reset` is low, every output is 0 (write enables combinationally gated), including the counters.
  - First fetch strobe occurs in the cycle after release.
- Reset mid-operation (including mid-wait) abandons the instruction. No partial write is retried.
- Cycles per instruction with `mem_ready` tied high:
  - beq/bne/j: 3
  - R, I-type, sw: 4
  - lw: 5
- Each low `mem_ready` cycle in FETCH, MEM_READ or MEM_WRITE adds one cycle. The strobes stay asserted and stable throughout the wait.
- `mem_ready` is ignored in all other states.

## Configuration
- `MCFSM_PERF_COUNTER_EN` defined:
  - `cycle_count` increments every cycle not in TRAP.
  - `instr_count` increments on every transition into FETCH from a completing state.
  - Both wrap modulo 2^CNT_WIDTH.
- Undefined: both counters are tied to 0 and no counter flops are built.

## Structure
- Package `multicycle_pkg` holds the state encodings, opcode constants, ALUOp codes, and the PCSource/ALUSrcB select codes.
- One sub-module, `multicycle_perf_counter`: two CNT_WIDTH counters with enables. It is instantiated only under the macro.

## Test plan
- R-type (OP=0x00), `mem_ready`=1 → states 0,1,6,7,0. RegWrite=1 and RegDst=1 only in cycle 4. instr_count +1.
- lw (0x23) with `mem_ready` low for 2 cycles in MEM_READ → states 0,1,2,3,3,3,4,0. MemRead and IorD stable during the wait.
- beq (0x04) then bne (0x05) → 3 cycles each. PCWriteCondEQ is high only in BRANCH for beq; PCWriteCondNE only for bne.
- ori (0x0D) → ALUOp=011 in I_EXEC, then RegWrite=1 with RegDst=0.
- OP=0x3F → TRAP after DECODE, illegal_op=1, cycle_count frozen. Reset returns to FETCH with illegal_op=0.
- Assert `reset` during MEM_WRITE wait → MemWrite drops to 0 immediately and counters read 0. After release, the first cycle is FETCH.

Source files
------------

// File: rtl/multicycle_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_pkg
// Description : Shared definitions for the multicycle MIPS controller:
//               state encodings, opcode constants, ALUOp codes, PCSource and
//               ALUSrcB select codes, plus small decode helpers.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package multicycle_pkg;

  // State encodings are architecturally visible on state_out, so the values
  // are fixed explicitly rather than left to enumeration order.
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_I_EXEC    = 4'd10,
    S_I_WB      = 4'd11,
    S_TRAP      = 4'd12
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // ALU operation codes
  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;
  localparam logic [2:0] ALUOP_OR    = 3'b011;
  localparam logic [2:0] ALUOP_AND   = 3'b100;
  localparam logic [2:0] ALUOP_LUI   = 3'b101;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // Dispatch from DECODE on the opcode class; unknown opcodes trap.
  function automatic state_t decode_next(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW:                     return S_MEM_ADDR;
      OP_RTYPE:                         return S_R_EXEC;
      OP_BEQ, OP_BNE:                   return S_BRANCH;
      OP_J:                             return S_JUMP;
      OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: return S_I_EXEC;
      default:                          return S_TRAP;
    endcase
  endfunction

  // ALU operation for the immediate-class execute step.
  function automatic logic [2:0] i_type_alu_op(input logic [5:0] op);
    case (op)
      OP_ANDI: return ALUOP_AND;
      OP_ORI:  return ALUOP_OR;
      OP_LUI:  return ALUOP_LUI;
      default: return ALUOP_ADD;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_perf_counter.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_perf_counter
// Description : Two free-running, wrapping performance counters with
//               individual count enables.
// Ports       : clk            - system clock
//               reset          - asynchronous active-low reset
//               cycle_en_i     - advance cycle_count_o this cycle
//               instr_en_i     - advance instr_count_o this cycle
//               cycle_count_o  - cycle counter value
//               instr_count_o  - retired-instruction counter value
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_perf_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cycle_en_i,
  input  logic                 instr_en_i,
  output logic [CNT_WIDTH-1:0] cycle_count_o,
  output logic [CNT_WIDTH-1:0] instr_count_o
);

  logic [CNT_WIDTH-1:0] cycle_q, cycle_d;
  logic [CNT_WIDTH-1:0] instr_q, instr_d;

  // Natural binary overflow gives the modulo-2^CNT_WIDTH wrap.
  always_comb begin
    cycle_d = cycle_q;
    instr_d = instr_q;
    if (cycle_en_i) cycle_d = cycle_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    if (instr_en_i) instr_d = instr_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      cycle_q <= cycle_d;
      instr_q <= instr_d;
    end
  end

  assign cycle_count_o = cycle_q;
  assign instr_count_o = instr_q;

endmodule
`default_nettype wire

// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_fsm
// Description : Moore sequencing controller for a multicycle MIPS datapath
//               with shared instruction/data memory and a mem_ready stall
//               handshake.
// Config      : define MCFSM_PERF_COUNTER_EN to build the cycle/instruction
//               performance counters; otherwise both read as zero.
// Ports       : clk, reset (async active-low), OP (IR[31:26]), mem_ready;
//               PC/IR/memory/register-file/ALU controls; illegal_op;
//               state_out; cycle_count, instr_count.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_fsm
  import multicycle_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           OP,
  input  logic                 mem_ready,
  output logic                 PCWrite,
  output logic                 PCWriteCondEQ,
  output logic                 PCWriteCondNE,
  output logic [1:0]           PCSource,
  output logic                 IorD,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 RegDst,
  output logic                 MemtoReg,
  output logic                 RegWrite,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [2:0]           ALUOp,
  output logic                 illegal_op,
  output logic [3:0]           state_out,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] instr_count
);

  state_t state_q, state_d;

  // Ungated control values decoded from the current state.
  logic       pc_write, cond_eq, cond_ne, ior_d, mem_rd, mem_wr, ir_wr;
  logic       reg_dst, mem_to_reg, reg_wr, src_a, illegal;
  logic [1:0] pc_src, src_b;
  logic [2:0] alu_op;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    cond_eq    = 1'b0;
    cond_ne    = 1'b0;
    pc_src     = PCSRC_ALU;
    ior_d      = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    ir_wr      = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_wr     = 1'b0;
    src_a      = 1'b0;
    src_b      = SRCB_REG;
    alu_op     = ALUOP_ADD;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        // PC+4 is computed every fetch cycle, but PC and IR only latch on
        // the cycle the memory actually delivers the instruction.
        mem_rd   = 1'b1;
        src_b    = SRCB_FOUR;
        ir_wr    = mem_ready;
        pc_write = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Speculative branch target (PC + imm<<2) lands in ALUOut.
        src_b   = SRCB_IMM_SH2;
        state_d = decode_next(OP);
      end
      S_MEM_ADDR: begin
        src_a   = 1'b1;
        src_b   = SRCB_IMM;
        state_d = (OP == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mem_rd = 1'b1;
        ior_d  = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_wr     = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_wr = 1'b1;
        ior_d  = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_R_EXEC: begin
        src_a   = 1'b1;
        alu_op  = ALUOP_FUNCT;
        state_d = S_R_WB;
      end
      S_R_WB: begin
        reg_wr  = 1'b1;
        reg_dst = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        // Compare A-B; the datapath qualifies these with the ALU Zero flag.
        src_a   = 1'b1;
        alu_op  = ALUOP_SUB;
        pc_src  = PCSRC_ALUOUT;
        cond_eq = (OP == OP_BEQ);
        cond_ne = (OP == OP_BNE);
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = PCSRC_JUMP;
        state_d  = S_FETCH;
      end
      S_I_EXEC: begin
        src_a   = 1'b1;
        src_b   = SRCB_IMM;
        alu_op  = i_type_alu_op(OP);
        state_d = S_I_WB;
      end
      S_I_WB: begin
        reg_wr  = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: begin
        // Terminal: only reset leaves this state.
        illegal = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Every output is forced low while reset is held so that an in-flight
  // memory write or register write is cut off without waiting for a clock.
  assign PCWrite       = reset & pc_write;
  assign PCWriteCondEQ = reset & cond_eq;
  assign PCWriteCondNE = reset & cond_ne;
  assign PCSource      = reset ? pc_src : 2'b00;
  assign IorD          = reset & ior_d;
  assign MemRead       = reset & mem_rd;
  assign MemWrite      = reset & mem_wr;
  assign IRWrite       = reset & ir_wr;
  assign RegDst        = reset & reg_dst;
  assign MemtoReg      = reset & mem_to_reg;
  assign RegWrite      = reset & reg_wr;
  assign ALUSrcA       = reset & src_a;
  assign ALUSrcB       = reset ? src_b : 2'b00;
  assign ALUOp         = reset ? alu_op : 3'b000;
  assign illegal_op    = reset & illegal;
  assign state_out     = reset ? state_q : 4'd0;

`ifdef MCFSM_PERF_COUNTER_EN
  logic                 cycle_en, instr_en;
  logic [CNT_WIDTH-1:0] cycle_cnt, instr_cnt;

  // An instruction retires on any edge that re-enters FETCH from another
  // state; FETCH-to-FETCH stall cycles are not retirements.
  assign cycle_en = (state_q != S_TRAP);
  assign instr_en = (state_d == S_FETCH) && (state_q != S_FETCH);

  multicycle_perf_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_perf (
    .clk           (clk),
    .reset         (reset),
    .cycle_en_i    (cycle_en),
    .instr_en_i    (instr_en),
    .cycle_count_o (cycle_cnt),
    .instr_count_o (instr_cnt)
  );

  assign cycle_count = reset ? cycle_cnt : {CNT_WIDTH{1'b0}};
  assign instr_count = reset ? instr_cnt : {CNT_WIDTH{1'b0}};
`else
  assign cycle_count = {CNT_WIDTH{1'b0}};
  assign instr_count = {CNT_WIDTH{1'b0}};
`endif

endmodule
`default_nettype wire
